// File: rtl/regfile_wb_ctrl.sv
// Register-file write-port controller: WB stage has priority, MDU results queue and drain into idle slots.
// Optional forwarding from the MDU queue is enabled with `define RFWB_FWD_EN.
module regfile_wb_ctrl #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32,
    parameter int AW    = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     pipe_we,
    input  logic [AW-1:0]            pipe_wa,
    input  logic [WIDTH-1:0]         pipe_wd,
    input  logic                     mdu_valid,
    output logic                     mdu_ready,
    input  logic [AW-1:0]            mdu_wa,
    input  logic [WIDTH-1:0]         mdu_wd,
    input  logic [AW-1:0]            dec_ra1,
    input  logic [AW-1:0]            dec_ra2,
    input  logic [AW-1:0]            dec_wa,
`ifdef RFWB_FWD_EN
    output logic                     fwd1_en,
    output logic [WIDTH-1:0]         fwd1_d,
    output logic                     fwd2_en,
    output logic [WIDTH-1:0]         fwd2_d,
`endif
    output logic                     hazard,
    output logic                     we3,
    output logic [AW-1:0]            wa3,
    output logic [WIDTH-1:0]         wd3,
    output logic [$clog2(DEPTH):0]   fifo_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0]    q_wa [DEPTH];
    logic [WIDTH-1:0] q_wd [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    cnt;
    logic [DEPTH-1:0] q_vld;

    logic pipe_hit;
    logic pop;
    logic push;
    logic pend_pipe;

    assign mdu_ready = (cnt != CW'(DEPTH));
    assign fifo_cnt  = cnt;
    assign pipe_hit  = pipe_we && (pipe_wa != '0) && !reset;
    assign pop       = !pipe_hit && (cnt != '0);
    assign push      = mdu_valid && mdu_ready && (mdu_wa != '0);

    // an entry is live if its distance from the head is below the count
    always_comb begin
        logic [PW-1:0] off;
        off   = '0;
        q_vld = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off      = PW'(i) - rd_ptr;
            q_vld[i] = (CW'(off) < cnt);
        end
    end

    function automatic logic pend(input logic [AW-1:0] r);
        logic hit;
        hit = mdu_valid && (mdu_wa == r);
        for (int i = 0; i < DEPTH; i++)
            if (q_vld[i] && (q_wa[i] == r))
                hit = 1'b1;
        return hit && (r != '0);
    endfunction

    always_comb begin
        pend_pipe = pend(pipe_wa);
`ifdef RFWB_FWD_EN
        hazard = ((dec_ra1 != '0) && mdu_valid && (mdu_wa == dec_ra1))
               | ((dec_ra2 != '0) && mdu_valid && (mdu_wa == dec_ra2))
               | pend(dec_wa);
`else
        hazard = pend(dec_ra1) | pend(dec_ra2) | pend(dec_wa);
`endif
    end

`ifdef RFWB_FWD_EN
    // scan oldest to youngest so the youngest match wins
    always_comb begin
        logic [PW-1:0] idx;
        idx     = '0;
        fwd1_en = 1'b0;
        fwd1_d  = '0;
        fwd2_en = 1'b0;
        fwd2_d  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr + PW'(k);
            if (CW'(k) < cnt) begin
                if ((dec_ra1 != '0) && (q_wa[idx] == dec_ra1)) begin
                    fwd1_en = 1'b1;
                    fwd1_d  = q_wd[idx];
                end
                if ((dec_ra2 != '0) && (q_wa[idx] == dec_ra2)) begin
                    fwd2_en = 1'b1;
                    fwd2_d  = q_wd[idx];
                end
            end
        end
    end
`endif

    always_comb begin
        we3 = 1'b0;
        wa3 = '0;
        wd3 = '0;
        if (pipe_hit) begin
            we3 = 1'b1;
            wa3 = pipe_wa;
            wd3 = pipe_wd;
        end else if (pop) begin
            we3 = 1'b1;
            wa3 = q_wa[rd_ptr];
            wd3 = q_wd[rd_ptr];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            cnt <= cnt + CW'(push) - CW'(pop);
        end
    end

    // payload needs no reset: liveness comes from the pointers and count
    always_ff @(posedge clk) begin
        if (push) begin
            q_wa[wr_ptr] <= mdu_wa;
            q_wd[wr_ptr] <= mdu_wd;
        end
    end

    a_pipe_no_pending: assert property (
        @(posedge clk) disable iff (reset) !(pipe_hit && pend_pipe));

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Scoreboard bench for regfile_wb_ctrl: queue-based reference model, decoupled monitor.
// Also exercises the forwarding ports when built with RFWB_FWD_EN.
module tb_regfile_wb_ctrl;

    localparam int DEPTH = 4;
    localparam int WIDTH = 32;
    localparam int AW    = 5;
    localparam int CW    = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic             pipe_we;
    logic [AW-1:0]    pipe_wa;
    logic [WIDTH-1:0] pipe_wd;
    logic             mdu_valid;
    logic             mdu_ready;
    logic [AW-1:0]    mdu_wa;
    logic [WIDTH-1:0] mdu_wd;
    logic [AW-1:0]    dec_ra1;
    logic [AW-1:0]    dec_ra2;
    logic [AW-1:0]    dec_wa;
    logic             hazard;
    logic             we3;
    logic [AW-1:0]    wa3;
    logic [WIDTH-1:0] wd3;
    logic [CW-1:0]    fifo_cnt;
`ifdef RFWB_FWD_EN
    logic             fwd1_en;
    logic [WIDTH-1:0] fwd1_d;
    logic             fwd2_en;
    logic [WIDTH-1:0] fwd2_d;
`endif

    regfile_wb_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AW(AW)) dut (
        .clk(clk), .reset(reset),
        .pipe_we(pipe_we), .pipe_wa(pipe_wa), .pipe_wd(pipe_wd),
        .mdu_valid(mdu_valid), .mdu_ready(mdu_ready),
        .mdu_wa(mdu_wa), .mdu_wd(mdu_wd),
        .dec_ra1(dec_ra1), .dec_ra2(dec_ra2), .dec_wa(dec_wa),
`ifdef RFWB_FWD_EN
        .fwd1_en(fwd1_en), .fwd1_d(fwd1_d),
        .fwd2_en(fwd2_en), .fwd2_d(fwd2_d),
`endif
        .hazard(hazard), .we3(we3), .wa3(wa3), .wd3(wd3),
        .fifo_cnt(fifo_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0]    wa;
        logic [WIDTH-1:0] wd;
    } wr_t;

    typedef struct {
        logic          we;
        logic          rdy;
        logic [CW-1:0] cnt;
        logic          hz;
    } st_t;

    wr_t mq[$];
    wr_t wr_q[$];
    st_t st_q[$];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic m_pend(input logic [AW-1:0] r, input logic mv,
                                    input logic [AW-1:0] mwa);
        if (r == 0) return 1'b0;
        if (mv && mwa == r) return 1'b1;
        foreach (mq[i]) if (mq[i].wa == r) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic m_haz(input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                                   input logic [AW-1:0] rw, input logic mv,
                                   input logic [AW-1:0] mwa);
`ifdef RFWB_FWD_EN
        return (r1 != 0 && mv && mwa == r1) || (r2 != 0 && mv && mwa == r2)
            || m_pend(rw, mv, mwa);
`else
        return m_pend(r1, mv, mwa) || m_pend(r2, mv, mwa) || m_pend(rw, mv, mwa);
`endif
    endfunction

    // one clock of stimulus; the model predicts this cycle's outputs
    task automatic cycle(input logic pwe, input logic [AW-1:0] pwa,
                         input logic [WIDTH-1:0] pwd, input logic mv,
                         input logic [AW-1:0] mwa, input logic [WIDTH-1:0] mwd,
                         input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                         input logic [AW-1:0] rw, output logic acc);
        st_t s;
        wr_t w;
        logic rdy;
        @(posedge clk);
        #1;
        pipe_we = pwe; pipe_wa = pwa; pipe_wd = pwd;
        mdu_valid = mv; mdu_wa = mwa; mdu_wd = mwd;
        dec_ra1 = r1; dec_ra2 = r2; dec_wa = rw;
        rdy   = mq.size() < DEPTH;
        s.rdy = rdy;
        s.cnt = CW'(mq.size());
        s.hz  = m_haz(r1, r2, rw, mv, mwa);
        s.we  = 1'b0;
        if (pwe && pwa != 0) begin
            s.we = 1'b1;
            w.wa = pwa;
            w.wd = pwd;
            wr_q.push_back(w);
        end else if (mq.size() > 0) begin
            s.we = 1'b1;
            wr_q.push_back(mq.pop_front());
        end
        acc = mv && rdy;
        if (acc && mwa != 0) begin
            w.wa = mwa;
            w.wd = mwd;
            mq.push_back(w);
        end
        st_q.push_back(s);
    endtask

    always @(negedge clk) begin
        st_t s;
        wr_t w;
        if (st_q.size() > 0) begin
            s = st_q.pop_front();
            chk("we3", we3, s.we);
            chk("mdu_ready", mdu_ready, s.rdy);
            chk("fifo_cnt", fifo_cnt, s.cnt);
            chk("hazard", hazard, s.hz);
            if (!s.we) begin
                chk("wa3_idle", wa3, 0);
                chk("wd3_idle", wd3, 0);
            end
        end
        if (we3) begin
            if (wr_q.size() == 0) begin
                chk("unexpected_write_wa3", wa3, 0);
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_write: wa3=%0d wd3=%0h with no write expected", wa3, wd3);
            end else begin
                w = wr_q.pop_front();
                chk("wa3", wa3, w.wa);
                chk("wd3", wd3, w.wd);
            end
        end
    end

    logic             acc;
    logic             mv_c;
    logic [AW-1:0]    mwa_c;
    logic [WIDTH-1:0] mwd_c;
    logic             pwe_r;
    logic [AW-1:0]    pwa_r;

    initial begin
        reset = 1'b1;
        pipe_we = 1'b1; pipe_wa = 5; pipe_wd = 32'hAAAA;
        mdu_valid = 1'b0; mdu_wa = '0; mdu_wd = '0;
        dec_ra1 = '0; dec_ra2 = '0; dec_wa = '0;
        #2;
        chk("rst_we3", we3, 0);
        chk("rst_wa3", wa3, 0);
        chk("rst_wd3", wd3, 0);
        chk("rst_cnt", fifo_cnt, 0);
        chk("rst_ready", mdu_ready, 1);
        chk("rst_hazard", hazard, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        pipe_we = 1'b0;

        // WB priority over a queued MDU result
        cycle(1, 5, 32'hAAAA, 1, 7, 32'h1234, 7, 0, 0, acc);
        cycle(1, 5, 32'hAAAA, 0, 0, 0, 7, 0, 0, acc);
        cycle(1, 5, 32'hAAAA, 0, 0, 0, 0, 0, 0, acc);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, acc);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, acc);

        // fill past DEPTH, then release the pipe so the queue drains and wraps
        for (int k = 1; k <= 6; k++) begin
            int tries;
            tries = 0;
            acc = 1'b0;
            while (!acc && tries < 20) begin
                cycle(tries < 2, 10, 32'hB000 + k, 1, AW'(k), 32'hC000 + k,
                      0, 0, 0, acc);
                tries++;
            end
            if (!acc) begin
                n_chk++;
                n_fail++;
                $display("FAIL mdu_accept_timeout: entry %0d not accepted, required accept", k);
            end
        end
        repeat (8) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, acc);

        // hazard on a queued destination, cleared after it drains
        cycle(1, 10, 32'h1, 1, 9, 32'h99, 0, 9, 0, acc);
        cycle(1, 10, 32'h2, 0, 0, 0, 0, 9, 0, acc);
        cycle(1, 10, 32'h3, 0, 0, 0, 0, 0, 0, acc);
        cycle(1, 10, 32'h4, 0, 0, 0, 9, 0, 9, acc);
        cycle(0, 0, 0, 0, 0, 0, 0, 9, 0, acc);
        cycle(0, 0, 0, 0, 0, 0, 0, 9, 0, acc);

        // r0 on either source is a no-op
        cycle(1, 10, 32'h5, 1, 12, 32'h1212, 0, 0, 0, acc);
        cycle(1, 0, 32'hDEAD, 0, 0, 0, 0, 0, 0, acc);
        cycle(0, 0, 0, 1, 0, 32'hBEEF, 0, 0, 0, acc);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, acc);

`ifdef RFWB_FWD_EN
        cycle(1, 10, 32'h6, 1, 3, 32'h11, 0, 0, 0, acc);
        cycle(1, 10, 32'h7, 1, 3, 32'h22, 0, 0, 0, acc);
        cycle(1, 10, 32'h8, 0, 0, 0, 3, 0, 0, acc);
        #1;
        chk("fwd1_en", fwd1_en, 1);
        chk("fwd1_d", fwd1_d, 32'h22);
        chk("fwd2_en", fwd2_en, 0);
        cycle(1, 10, 32'h9, 0, 0, 0, 0, 0, 3, acc);
        repeat (3) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, acc);
`endif

        // reset with two entries queued discards them
        cycle(1, 10, 32'hA, 1, 3, 32'h33, 0, 0, 0, acc);
        cycle(1, 10, 32'hB, 1, 4, 32'h44, 0, 0, 0, acc);
        @(posedge clk);
        #1;
        mdu_valid = 1'b0; mdu_wa = '0;
        chk("prerst_cnt", fifo_cnt, mq.size());
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_we3", we3, 0);
        chk("midrst_cnt", fifo_cnt, 0);
        chk("midrst_ready", mdu_ready, 1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        pipe_we = 1'b0;
        mq.delete();
        repeat (3) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, acc);

        // randomized traffic; MDU holds its request until accepted
        mv_c = 1'b0; mwa_c = '0; mwd_c = '0;
        for (int n = 0; n < 400; n++) begin
            if (!mv_c && $urandom_range(0, 2) == 0) begin
                mv_c  = 1'b1;
                mwa_c = AW'($urandom_range(0, 7));
                mwd_c = $urandom;
            end
            pwe_r = ($urandom_range(0, 2) != 0);
            pwa_r = AW'($urandom_range(0, 7));
            if (m_pend(pwa_r, mv_c, mwa_c)) pwe_r = 1'b0;
            cycle(pwe_r, pwa_r, $urandom, mv_c, mwa_c, mwd_c,
                  AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
                  AW'($urandom_range(0, 7)), acc);
            if (acc) mv_c = 1'b0;
        end
        repeat (6) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, acc);
        @(negedge clk);
        #1;
        chk("wr_q_drained", wr_q.size(), 0);
        chk("model_empty", fifo_cnt, mq.size());

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
